interconexion_param: RTL and testbench

Parametrised N×N packet switch built from FIFOs. Each of `NUM_PORTS` input FIFOs holds words from the stimulus side. A work-conserving arbiter moves at most one word per cycle from an input FIFO to the output FIFO named by the word's destination field, and holds a word back while its target output FIFO is almost full. This is the generalised replacement for the fixed 4-port FIFO/mux/demux/arbiter assembly. It adds configurable port count, depth and threshold, per-destination routing, round-robin fairness and overflow reporting.

---
 rtl/interconexion_pkg.sv | 24 ++
 rtl/fifo_param.sv | 83 ++++++++
 rtl/interconexion_param.sv | 159 +++++++++++++++
 tb/tb_interconexion_param.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/interconexion_pkg.sv
// Shared constants and helpers for the interconexion_param packet switch.
// Holds the default parameter values, the derived width constants for the
// default configuration, and dst_of(), which extracts the destination field
// (the low log2(num_ports) bits) from a word.
package interconexion_pkg;

    localparam int unsigned DEF_DATA_WIDTH   = 10;
    localparam int unsigned DEF_NUM_PORTS    = 4;
    localparam int unsigned DEF_FIFO_DEPTH   = 8;
    localparam int unsigned DEF_AF_THRESHOLD = 2;

    localparam int unsigned DST_W = $clog2(DEF_NUM_PORTS);
    localparam int unsigned CNT_W = $clog2(DEF_FIFO_DEPTH) + 1;

    // Widest word dst_of() accepts; callers zero-extend narrower words.
    localparam int unsigned MAX_WORD_W = 32;

    // num_ports is a power of two, so masking keeps exactly the destination bits.
    function automatic int unsigned dst_of(input logic [MAX_WORD_W-1:0] word,
                                           input int unsigned num_ports);
        return word & (num_ports - 1);
    endfunction

endpackage

// File: rtl/fifo_param.sv
// Circular show-ahead FIFO used for both the input and the output side of the
// switch.
// Ports:
//   clk_i, rst_i         clock, asynchronous active-high reset
//   push_i, wdata_i      write strobe and data (dropped when full unless popped)
//   pop_i                read strobe (ignored when empty)
//   head_o               word at the read pointer, forced to 0 while empty
//   empty_o, full_o      status decoded from the registered count
//   almost_full_o        count >= FIFO_DEPTH - AF_THRESHOLD
module fifo_param
    import interconexion_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned AF_THRESHOLD = DEF_AF_THRESHOLD
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic                  pop_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] head_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic                  almost_full_o
);

    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned FCNT_W = PTR_W + 1;

    logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]      wptr_q, wptr_d;
    logic [PTR_W-1:0]      rptr_q, rptr_d;
    logic [FCNT_W-1:0]     count_q, count_d;
    logic                  do_push, do_pop;

    assign empty_o       = (count_q == '0);
    assign full_o        = (count_q == FCNT_W'(FIFO_DEPTH));
    assign almost_full_o = (count_q >= FCNT_W'(FIFO_DEPTH - AF_THRESHOLD));

    assign do_pop  = pop_i && !empty_o;
    // A pop in the same cycle frees the slot, so a push to a full FIFO still lands.
    assign do_push = push_i && (!full_o || do_pop);

    assign head_o = empty_o ? '0 : mem_q[rptr_q];

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + PTR_W'(1);
        end
        if (do_pop) begin
            rptr_d = rptr_q + PTR_W'(1);
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + FCNT_W'(1);
            2'b01:   count_d = count_q - FCNT_W'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: head_o is masked while the FIFO is empty.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/interconexion_param.sv
// NUM_PORTS x NUM_PORTS packet switch built from FIFOs. Words pushed into the
// input FIFOs are moved, at most one per cycle, to the output FIFO named by
// their low destination bits. An input whose target output is almost full is
// held back without blocking the others.
// Build option: define INTERCON_STRICT_PRIO_EN for fixed lowest-index-wins
// priority; by default the arbiter is round-robin.
// Ports:
//   clk, reset    clock, asynchronous active-high reset
//   push_in       per-input write strobe; data_in lane i feeds input i
//   pop_out       per-output read strobe; data_out lane j is output j's head
//   empty_fifos   [i] input i empty, [NUM_PORTS+j] output j empty
//   full_in       input FIFO full
//   overflow_in   sticky: a push to input i was dropped
//   xfer_valid/xfer_src/xfer_dst  transfer committed at the next edge
module interconexion_param
    import interconexion_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = DEF_DATA_WIDTH,
    parameter int unsigned NUM_PORTS    = DEF_NUM_PORTS,
    parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH,
    parameter int unsigned AF_THRESHOLD = DEF_AF_THRESHOLD,
    localparam int unsigned PORT_W      = $clog2(NUM_PORTS)
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [NUM_PORTS-1:0]            push_in,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] data_in,
    input  logic [NUM_PORTS-1:0]            pop_out,
    output logic [NUM_PORTS*DATA_WIDTH-1:0] data_out,
    output logic [2*NUM_PORTS-1:0]          empty_fifos,
    output logic [NUM_PORTS-1:0]            full_in,
    output logic [NUM_PORTS-1:0]            overflow_in,
    output logic                            xfer_valid,
    output logic [PORT_W-1:0]               xfer_src,
    output logic [PORT_W-1:0]               xfer_dst
);

    logic [DATA_WIDTH-1:0] in_head  [NUM_PORTS];
    logic [PORT_W-1:0]     head_dst [NUM_PORTS];
    logic [NUM_PORTS-1:0]  in_empty, in_full, in_pop;
    logic [NUM_PORTS-1:0]  out_empty, out_af, out_push;
    logic [NUM_PORTS-1:0]  unused_in_af, unused_out_full;
    logic [NUM_PORTS-1:0]  eligible;
    logic [NUM_PORTS-1:0]  overflow_q, overflow_d;
    logic                  grant_valid;
    logic [PORT_W-1:0]     grant_src, grant_dst;
    logic [DATA_WIDTH-1:0] xfer_word;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
        fifo_param #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .AF_THRESHOLD(AF_THRESHOLD)
        ) u_in_fifo (
            .clk_i        (clk),
            .rst_i        (reset),
            .push_i       (push_in[i]),
            .pop_i        (in_pop[i]),
            .wdata_i      (data_in[i*DATA_WIDTH +: DATA_WIDTH]),
            .head_o       (in_head[i]),
            .empty_o      (in_empty[i]),
            .full_o       (in_full[i]),
            .almost_full_o(unused_in_af[i])
        );

        fifo_param #(
            .DATA_WIDTH  (DATA_WIDTH),
            .FIFO_DEPTH  (FIFO_DEPTH),
            .AF_THRESHOLD(AF_THRESHOLD)
        ) u_out_fifo (
            .clk_i        (clk),
            .rst_i        (reset),
            .push_i       (out_push[i]),
            .pop_i        (pop_out[i]),
            .wdata_i      (xfer_word),
            .head_o       (data_out[i*DATA_WIDTH +: DATA_WIDTH]),
            .empty_o      (out_empty[i]),
            .full_o       (unused_out_full[i]),
            .almost_full_o(out_af[i])
        );

        assign head_dst[i] = PORT_W'(dst_of(MAX_WORD_W'(in_head[i]), NUM_PORTS));
    end

    always_comb begin
        eligible = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            eligible[i] = !in_empty[i] && !out_af[head_dst[i]];
        end
    end

`ifdef INTERCON_STRICT_PRIO_EN
    // Descending scan so the lowest eligible index is the last one written.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (eligible[k]) begin
                grant_valid = 1'b1;
                grant_src   = PORT_W'(k);
            end
        end
    end
`else
    logic [PORT_W-1:0] rr_q, rr_d;

    // Offsets are PORT_W wide, so rr_q + k wraps modulo NUM_PORTS for free.
    always_comb begin
        grant_valid = 1'b0;
        grant_src   = '0;
        for (int k = NUM_PORTS - 1; k >= 0; k--) begin
            if (eligible[rr_q + PORT_W'(k)]) begin
                grant_valid = 1'b1;
                grant_src   = rr_q + PORT_W'(k);
            end
        end
        rr_d = grant_valid ? grant_src + PORT_W'(1) : rr_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rr_q <= '0;
        end else begin
            rr_q <= rr_d;
        end
    end
`endif

    assign grant_dst = head_dst[grant_src];
    assign xfer_word = in_head[grant_src];

    always_comb begin
        in_pop   = '0;
        out_push = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            in_pop[i]   = grant_valid && (grant_src == PORT_W'(i));
            out_push[i] = grant_valid && (grant_dst == PORT_W'(i));
        end
    end

    // Only a push that is actually dropped counts; a same-cycle pop makes room.
    assign overflow_d = overflow_q | (push_in & in_full & ~in_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            overflow_q <= '0;
        end else begin
            overflow_q <= overflow_d;
        end
    end

    assign empty_fifos = {out_empty, in_empty};
    assign full_in     = in_full;
    assign overflow_in = overflow_q;
    assign xfer_valid  = grant_valid;
    assign xfer_src    = grant_src;
    assign xfer_dst    = grant_dst;

endmodule

// File: tb/tb_interconexion_param.sv
module tb_interconexion_param;

    localparam int NP    = 4;
    localparam int DW    = 10;
    localparam int DEPTH = 8;
    localparam int AF    = 2;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [NP-1:0]    push_in = '0;
    logic [NP*DW-1:0] data_in = '0;
    logic [NP-1:0]    pop_out = '0;
    logic [NP*DW-1:0] data_out;
    logic [2*NP-1:0]  empty_fifos;
    logic [NP-1:0]    full_in;
    logic [NP-1:0]    overflow_in;
    logic             xfer_valid;
    logic [1:0]       xfer_src;
    logic [1:0]       xfer_dst;

    interconexion_param #(
        .DATA_WIDTH  (DW),
        .NUM_PORTS   (NP),
        .FIFO_DEPTH  (DEPTH),
        .AF_THRESHOLD(AF)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_in    (push_in),
        .data_in    (data_in),
        .pop_out    (pop_out),
        .data_out   (data_out),
        .empty_fifos(empty_fifos),
        .full_in    (full_in),
        .overflow_in(overflow_in),
        .xfer_valid (xfer_valid),
        .xfer_src   (xfer_src),
        .xfer_dst   (xfer_dst)
    );

    always #5 clk = ~clk;

    // Behavioural model: one queue per FIFO plus a round-robin start index.
    logic [DW-1:0] in_q  [NP][$];
    logic [DW-1:0] out_q [NP][$];
    logic [NP-1:0] m_ovf = '0;
    int            m_rr = 0;
    int            n_tests = 0;
    int            n_fail = 0;
    bit            chk_en = 1'b0;

    function automatic int wdst(input logic [DW-1:0] w);
        return int'(w) % NP;
    endfunction

    // Returns the input that wins this cycle, or -1 when none is eligible.
    function automatic int model_grant();
        int i;
        for (int k = 0; k < NP; k++) begin
`ifdef INTERCON_STRICT_PRIO_EN
            i = k;
`else
            i = (m_rr + k) % NP;
`endif
            if (in_q[i].size() > 0 && out_q[wdst(in_q[i][0])].size() < DEPTH - AF) begin
                return i;
            end
        end
        return -1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", name, $time, act, exp);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < NP; i++) begin
            in_q[i].delete();
            out_q[i].delete();
        end
        m_ovf = '0;
        m_rr  = 0;
    endtask

    task automatic model_step();
        int g;
        logic [DW-1:0] w;
        g = model_grant();
        for (int j = 0; j < NP; j++) begin
            if (pop_out[j] && out_q[j].size() > 0) begin
                w = out_q[j].pop_front();
            end
        end
        if (g >= 0) begin
            w = in_q[g].pop_front();
            out_q[wdst(w)].push_back(w);
            m_rr = (g + 1) % NP;
        end
        for (int i = 0; i < NP; i++) begin
            if (push_in[i]) begin
                if (in_q[i].size() < DEPTH) begin
                    in_q[i].push_back(data_in[i*DW +: DW]);
                end else begin
                    m_ovf[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic compare();
        int g;
        logic [NP*DW-1:0] exp_do;
        logic [2*NP-1:0]  exp_empty;
        logic [NP-1:0]    exp_full;
        g = model_grant();
        exp_do    = '0;
        exp_empty = '0;
        exp_full  = '0;
        for (int j = 0; j < NP; j++) begin
            if (out_q[j].size() > 0) exp_do[j*DW +: DW] = out_q[j][0];
            exp_empty[NP+j] = (out_q[j].size() == 0);
            exp_empty[j]    = (in_q[j].size() == 0);
            exp_full[j]     = (in_q[j].size() == DEPTH);
        end
        check("xfer_valid", 64'(xfer_valid), 64'(g >= 0));
        if (g >= 0) begin
            check("xfer_src", 64'(xfer_src), 64'(g));
            check("xfer_dst", 64'(xfer_dst), 64'(wdst(in_q[g][0])));
        end
        check("data_out", 64'(data_out), 64'(exp_do));
        check("empty_fifos", 64'(empty_fifos), 64'(exp_empty));
        check("full_in", 64'(full_in), 64'(exp_full));
        check("overflow_in", 64'(overflow_in), 64'(m_ovf));
    endtask

    // Model follows the DUT's edges and async reset.
    initial begin
        forever begin
            @(posedge clk or posedge reset);
            if (reset) model_clear();
            else model_step();
        end
    end

    // Single compare process, away from the active edge.
    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) compare();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        push_in = '0;
        pop_out = '0;
        reset   = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic put(input int i, input logic [DW-1:0] w);
        data_in[i*DW +: DW] = w;
        push_in[i] = 1'b1;
    endtask

    // Reset raised between edges; outputs must clear without waiting for a clock.
    task automatic midcycle_reset(input string tag);
        #2;
        reset = 1'b1;
        #1;
        check({tag, "_empty"}, 64'(empty_fifos), 64'hFF);
        check({tag, "_data"}, 64'(data_out), 64'h0);
        check({tag, "_xv"}, 64'(xfer_valid), 64'h0);
        check({tag, "_ovf"}, 64'(overflow_in), 64'h0);
        check({tag, "_full"}, 64'(full_in), 64'h0);
        push_in = '0;
        pop_out = '0;
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        #1;
        do_reset();
        chk_en = 1'b1;
        check("rst_empty", 64'(empty_fifos), 64'hFF);
        check("rst_data", 64'(data_out), 64'h0);

        // Single word to output 2.
        put(0, 10'h0A6);
        tick();
        push_in = '0;
        check("t2_grant", 64'(xfer_valid), 64'h1);
        check("t2_dst", 64'(xfer_dst), 64'h2);
        tick();
        check("t2_out_ne", 64'(empty_fifos[6]), 64'h0);
        check("t2_lane2", 64'(data_out[29:20]), 64'h0A6);
        pop_out[2] = 1'b1;
        tick();
        pop_out = '0;
        check("t2_out_e", 64'(empty_fifos[6]), 64'h1);

        // Fairness: all four inputs contend at once.
        do_reset();
        for (int i = 0; i < NP; i++) put(i, {8'(8'hA0 + i), 2'(3 - i)});
        tick();
        push_in = '0;
        for (int i = 0; i < NP; i++) begin
            check("t3_valid", 64'(xfer_valid), 64'h1);
            check("t3_src", 64'(xfer_src), 64'(i));
            tick();
        end
        put(0, {8'h11, 2'd0});
        put(1, {8'h22, 2'd1});
        tick();
        push_in = '0;
        check("t3_wrap_src", 64'(xfer_src), 64'h0);

        // Backpressure on output 1 while input 2 streams to output 3.
        do_reset();
        pop_out = 4'b1000;
        for (int k = 0; k < 8; k++) begin
            put(0, {8'(k), 2'd1});
            put(2, {8'(8'h40 + k), 2'd3});
            tick();
        end
        push_in = '0;
        repeat (20) tick();
        check("t4_model_out1", 64'(out_q[1].size()), 64'd6);
        check("t4_model_in0", 64'(in_q[0].size()), 64'd2);
        check("t4_in0_ne", 64'(empty_fifos[0]), 64'h0);
        check("t4_in2_drained", 64'(empty_fifos[2]), 64'h1);
        check("t4_out1_ne", 64'(empty_fifos[5]), 64'h0);
        check("t4_stalled", 64'(xfer_valid), 64'h0);
        check("t4_lane1", 64'(data_out[19:10]), 64'h001);
        pop_out = 4'b0010;
        tick();
        pop_out = '0;
        cnt = 0;
        repeat (6) begin
            if (xfer_valid) cnt++;
            tick();
        end
        check("t4_resume_once", 64'(cnt), 64'd1);
        check("t4_model_in0b", 64'(in_q[0].size()), 64'd1);

        // Overflow on input 1 with output 0 blocked.
        do_reset();
        for (int k = 0; k < 6; k++) begin
            put(0, {8'(k), 2'd0});
            tick();
        end
        push_in = '0;
        repeat (4) tick();
        for (int k = 0; k < 9; k++) begin
            put(1, {8'(8'h10 + k), 2'd0});
            tick();
            if (k == 7) begin
                check("t5_full", 64'(full_in[1]), 64'h1);
                check("t5_no_ovf_yet", 64'(overflow_in[1]), 64'h0);
            end
        end
        push_in = '0;
        check("t5_ovf", 64'(overflow_in[1]), 64'h1);
        repeat (5) tick();
        check("t5_ovf_sticky", 64'(overflow_in[1]), 64'h1);
        check("t5_full_hold", 64'(full_in[1]), 64'h1);
        midcycle_reset("t1");

`ifdef INTERCON_STRICT_PRIO_EN
        // Inputs 0 and 3 both kept eligible; 3 must never win.
        do_reset();
        pop_out = 4'b1111;
        for (int c = 0; c < 30; c++) begin
            put(0, {8'(c), 2'd1});
            put(3, {8'(8'h80 + c), 2'd2});
            tick();
            if (!empty_fifos[0]) check("t6_prio", 64'(xfer_src), 64'h0);
        end
        push_in = '0;
        pop_out = '0;
`endif

        // Randomised traffic; low then high drain rate.
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            push_in = 4'($urandom);
            data_in = 40'({$urandom, $urandom});
            for (int j = 0; j < NP; j++) begin
                pop_out[j] = ($urandom_range(0, 99) < ((c < 1000) ? 25 : 75));
            end
            tick();
            if (c == 1200) midcycle_reset("rnd_rst");
        end
        push_in = '0;
        pop_out = '0;
        repeat (3) tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
